// File: rtl/button_hold_scheduler_if.sv
// Event handshake between the hold scheduler (master) and its consumer (slave).
interface button_hold_scheduler_if #(
  parameter int N_BTN = 4
);
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_id;
  logic [1:0]    evt_kind;

  modport master (output evt_valid, output evt_id, output evt_kind, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_kind, output evt_ready);
endinterface

// File: rtl/button_hold_scheduler.sv
// One shared hold timer for N_BTN debounced buttons. The lowest-index pressed
// button is granted the timer; its hold is classified into SHORT / LONG /
// REPEAT / RELEASE events that land in a single valid/ready output register.
// The FSM never stalls: an event arriving while the register is full is lost
// and flagged on the sticky overrun output.
module button_hold_scheduler #(
  parameter int N_BTN         = 4,
  parameter int MIN_CYCLES    = 2,
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 50_000_000,
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int CW = $clog2(((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      i_btn,
  button_hold_scheduler_if.master evt,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [CW-1:0]         o_hold_count
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LONG} state_t;
  typedef enum logic [1:0] {K_SHORT = 2'b00, K_LONG = 2'b01, K_REPEAT = 2'b10, K_RELEASE = 2'b11} kind_t;

  state_t        r_state, w_state_nx;
  logic [IW-1:0] r_owner, w_owner_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;

  logic          w_emit;
  kind_t         w_kind;
  logic          w_grant_hit;
  logic [IW-1:0] w_grant_idx;

  logic          r_evt_valid;
  logic [IW-1:0] r_evt_id;
  kind_t         r_evt_kind;
  logic          r_overrun;

  // Priority pick of the lowest-index pressed button for the next grant.
  always_comb begin
    w_grant_hit = 1'b0;
    w_grant_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (i_btn[i]) begin
        w_grant_hit = 1'b1;
        w_grant_idx = IW'(i);
      end
    end
  end

  // State, owner and hold timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next-state and event decision. The timer is cleared on every event and
  // transition, so it never exceeds max(LONG,REPEAT)-1 and cannot wrap.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    w_emit     = 1'b0;
    w_kind     = K_SHORT;
    case (r_state)
      S_IDLE: begin
        if (w_grant_hit) begin
          w_owner_nx = w_grant_idx;
          w_cnt_nx   = CW'(1);        // the granting sample is the first high sample
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_btn[r_owner]) begin
          if (r_cnt == CW'(LONG_CYCLES - 1)) begin
            w_emit     = 1'b1;
            w_kind     = K_LONG;
            w_cnt_nx   = '0;
            w_state_nx = S_LONG;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end else begin
          w_emit     = (r_cnt >= CW'(MIN_CYCLES));   // too-brief presses vanish
          w_kind     = K_SHORT;
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end
      end
      S_LONG: begin
        if (i_btn[r_owner]) begin
          if (r_cnt == CW'(REPEAT_CYCLES - 1)) begin
            w_emit   = 1'b1;
            w_kind   = K_REPEAT;
            w_cnt_nx = '0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end else begin
          w_emit     = 1'b1;
          w_kind     = K_RELEASE;
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Output event register: load when empty or being drained, else drop and
  // flag overrun; a plain accept empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_kind  <= K_SHORT;
      r_overrun   <= 1'b0;
    end else if (w_emit) begin
      if (!r_evt_valid || evt.evt_ready) begin
        r_evt_valid <= 1'b1;
        r_evt_id    <= r_owner;
        r_evt_kind  <= w_kind;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (r_evt_valid && evt.evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_id    = r_evt_id;
  assign evt.evt_kind  = r_evt_kind;
  assign o_busy        = (r_state != S_IDLE);
  assign o_overrun     = r_overrun;
  assign o_hold_count  = r_cnt;

endmodule

// File: tb/tb_button_hold_scheduler.sv
// Bench for button_hold_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a model that
// counts high samples since the grant and derives events arithmetically.
module tb_button_hold_scheduler;
  localparam int N   = 4;
  localparam int MIN = 2;
  localparam int LNG = 8;
  localparam int REP = 4;
  localparam int CW  = $clog2(((LNG > REP) ? LNG : REP) + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  btn;
  logic          busy, overrun;
  logic [CW-1:0] hold_count;

  button_hold_scheduler_if #(.N_BTN(N)) bus ();

  button_hold_scheduler #(
    .N_BTN(N), .MIN_CYCLES(MIN), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(btn), .evt(bus.master),
    .o_busy(busy), .o_overrun(overrun), .o_hold_count(hold_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_n = number of high samples of the owner since (and including) its grant.
  bit m_busy, m_long, m_v, m_ovr;
  int m_own, m_n, m_id, m_kind;

  always @(posedge clk) begin
    bit ev;
    int kd;
    ev = 0; kd = 0;
    if (reset) begin
      m_busy = 0; m_long = 0; m_own = 0; m_n = 0;
      m_v = 0; m_id = 0; m_kind = 0; m_ovr = 0;
    end else begin
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (btn[i] && !m_busy) begin
            m_busy = 1; m_own = i; m_n = 1; m_long = 0;
          end
        end
      end else if (btn[m_own]) begin
        m_n++;
        if (m_n == LNG) begin
          ev = 1; kd = 1; m_long = 1;
        end else if (m_n > LNG && ((m_n - LNG) % REP) == 0) begin
          ev = 1; kd = 2;
        end
      end else begin
        if (m_long) begin ev = 1; kd = 3; end
        else if (m_n >= MIN) begin ev = 1; kd = 0; end
        m_busy = 0; m_long = 0; m_n = 0;
      end
      if (ev) begin
        if (!m_v || bus.evt_ready) begin
          m_v = 1; m_id = m_own; m_kind = kd;
        end else begin
          m_ovr = 1;
        end
      end else if (m_v && bus.evt_ready) begin
        m_v = 0;
      end
    end
  end

  function automatic int m_hold();
    if (!m_busy) return 0;
    if (m_long) return (m_n - LNG) % REP;
    return m_n;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("evt_valid",  int'(bus.evt_valid), int'(m_v));
      chk("evt_id",     int'(bus.evt_id),    m_id);
      chk("evt_kind",   int'(bus.evt_kind),  m_kind);
      chk("busy",       int'(busy),          int'(m_busy));
      chk("overrun",    int'(overrun),       int'(m_ovr));
      chk("hold_count", int'(hold_count),    m_hold());
    end
  end

  task automatic step(input logic [N-1:0] b);
    btn = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; btn = '0; bus.evt_ready = 1'b1;
    step('0); step('0);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset valid",   int'(bus.evt_valid), 0);
    chk("reset busy",    int'(busy), 0);
    chk("reset hold",    int'(hold_count), 0);
    chk("reset overrun", int'(overrun), 0);

    // 1: short press on btn[2]
    repeat (3) step(4'b0100);
    step(4'b0000);
    chk("t1 valid", int'(bus.evt_valid), 1);
    chk("t1 id",    int'(bus.evt_id), 2);
    chk("t1 kind",  int'(bus.evt_kind), 0);
    chk("t1 busy",  int'(busy), 0);
    step(4'b0000);
    chk("t1 valid drop", int'(bus.evt_valid), 0);

    // 2: one-cycle blip dropped
    step(4'b0010);
    chk("t2 busy", int'(busy), 1);
    step(4'b0000);
    chk("t2 busy off", int'(busy), 0);
    chk("t2 no event", int'(bus.evt_valid), 0);
    chk("t2 overrun",  int'(overrun), 0);

    // 3: long hold with repeats, then release
    for (int i = 1; i <= 17; i++) begin
      step(4'b0001);
      if (i == 8)  chk("t3 long kind",  int'(bus.evt_valid) * 4 + int'(bus.evt_kind), 5);
      if (i == 9)  chk("t3 gap",        int'(bus.evt_valid), 0);
      if (i == 12) chk("t3 rep1 kind",  int'(bus.evt_valid) * 4 + int'(bus.evt_kind), 6);
      if (i == 16) chk("t3 rep2 kind",  int'(bus.evt_valid) * 4 + int'(bus.evt_kind), 6);
    end
    step(4'b0000);
    chk("t3 release", int'(bus.evt_valid) * 4 + int'(bus.evt_kind), 7);
    step(4'b0000);

    // 4: simultaneous press, lower index wins, other measured from its grant
    repeat (3) step(4'b1010);
    step(4'b1000);
    chk("t4 short1 id", int'(bus.evt_valid) * 4 + int'(bus.evt_id), 5);
    chk("t4 idle",      int'(busy), 0);
    step(4'b1000);
    chk("t4 grant3",    int'(busy), 1);
    step(4'b1000);
    chk("t4 hold3",     int'(hold_count), 2);
    step(4'b0000);
    chk("t4 short3 id", int'(bus.evt_valid) * 4 + int'(bus.evt_id), 7);
    chk("t4 short3 kd", int'(bus.evt_kind), 0);
    step(4'b0000);

    // 5: stalled consumer, second event lost
    bus.evt_ready = 1'b0;
    repeat (2) step(4'b0001);
    step(4'b0000);
    step(4'b0000);
    repeat (2) step(4'b0001);
    step(4'b0000);
    chk("t5 held",    int'(bus.evt_valid), 1);
    chk("t5 overrun", int'(overrun), 1);
    bus.evt_ready = 1'b1;
    step(4'b0000);
    chk("t5 drained", int'(bus.evt_valid), 0);

    // 6: reset in LONG state aborts silently
    repeat (10) step(4'b0001);
    reset = 1'b1;
    step(4'b0001);
    chk("t6 valid",   int'(bus.evt_valid), 0);
    chk("t6 busy",    int'(busy), 0);
    chk("t6 hold",    int'(hold_count), 0);
    chk("t6 overrun", int'(overrun), 0);
    reset = 1'b0;
    repeat (7) step(4'b0001);
    chk("t6 pre long", int'(bus.evt_valid), 0);
    step(4'b0001);
    chk("t6 long", int'(bus.evt_valid) * 4 + int'(bus.evt_kind), 5);
    step(4'b0000);
    step(4'b0000);

    // randomized phase: slowly changing buttons, random backpressure, rare reset
    begin
      logic [N-1:0] b;
      b = '0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(7) == 0) b[$urandom_range(N-1)] ^= 1'b1;
        bus.evt_ready = ($urandom_range(3) != 0);
        reset = ($urandom_range(700) == 0);
        step(b);
      end
      reset = 1'b0;
      step('0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
